pc_fetch_sequencer: RTL
=======================

Name: pc_fetch_sequencer

Overview:
Sequences the program counter and instruction fetch for the multicycle variant of the RISC-V core. It owns the PC register and its PC+4 increment, drives a request/ready handshake to instruction memory, and holds the fetched instruction until the core consumes it. It accepts branch/jump redirects from the core and vectors misaligned targets to a fixed trap address.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; bits [1:0] forced to 0.
TRAP_VECTOR, 32'h0000_0100, PC value loaded on a misaligned redirect; bits [1:0] forced to 0.

Ports:
clk  in  1  single clock; all state updates on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
Stall  in  1  core not ready to consume Instr; holds the current instruction.
PCSrc  in  1  redirect select; sampled only when an instruction retires.
PCTarget  in  32  redirect target address.
IMemReq  out  1  fetch request to instruction memory.
IMemAddr  out  32  fetch address; equals PC.
IMemReady  in  1  memory accepts the request and returns data in the same cycle.
IMemRData  in  32  instruction word; valid when IMemReq and IMemReady are both 1.
Instr  out  32  registered instruction.
InstrValid  out  1  Instr is valid for the instruction at PC.
PC  out  32  current program counter.
PCPlus4  out  32  PC + 4, combinational, modulo 2^32.
Misaligned  out  1  one-cycle pulse when a misaligned redirect is trapped.
BadAddr  out  32  last misaligned PCTarget captured.

Behaviour:
- Reset (rst_n = 0, asynchronous): state = BOOT, PC = RESET_VECTOR, Instr = 0, InstrValid = 0, IMemReq = 0, Misaligned = 0, BadAddr = 0.
- FSM states: BOOT, REQ, VALID.
- BOOT: IMemReq = 0. On the first clock edge after rst_n goes high, move to REQ.
- REQ: IMemReq = 1 and IMemAddr = PC, both held stable until IMemReady = 1.
  - On an edge with IMemReady = 1: Instr <= IMemRData, InstrValid <= 1, move to VALID.
  - With IMemReady = 0: stay in REQ; there is no timeout.
- VALID: IMemReq = 0, InstrValid = 1.
  - Stall = 1: hold everything; PCSrc and PCTarget are ignored.
  - Stall = 0 (retire): InstrValid <= 0 and move to REQ. The next PC is chosen as follows:
    - PCSrc = 0: PC <= PC + 4.
    - PCSrc = 1 and PCTarget[1:0] == 0: PC <= PCTarget.
    - PCSrc = 1 and PCTarget[1:0] != 0: PC <= TRAP_VECTOR, BadAddr <= PCTarget, Misaligned = 1 for exactly the next cycle.
- PCSrc, PCTarget and Stall are don't-care in BOOT and REQ. A redirect can only happen at retirement.
- Wrap-around: PC = 32'hFFFF_FFFC with PCSrc = 0 gives PC = 32'h0000_0000 (no flag). PCPlus4 wraps the same way.
- Throughput: with IMemReady tied to 1 and Stall = 0, one instruction retires every 2 cycles (REQ, VALID).
- Reset mid-operation: IMemReq drops asynchronously. Any in-flight request is abandoned and memory must not depend on its completion. Fetch restarts at RESET_VECTOR.
- PC changes only on retirement or reset. Instr changes only on handshake completion or reset.

Test Plan:
1. Release reset with IMemReady = 1 and IMemRData = 32'h0000_0013 -> edge 1: BOOT to REQ with IMemAddr = 0; edge 2: Instr = 32'h13, InstrValid = 1; then retire -> PC = 4 and the next request is at 4.
2. Hold IMemReady = 0 for 5 cycles in REQ at PC = 8 -> IMemReq = 1 and IMemAddr = 8 stay stable for all 5 cycles; a ready pulse loads Instr exactly once.
3. In VALID, assert Stall = 1 for 3 cycles with PCSrc = 1 and PCTarget = 32'h40 -> PC, Instr and InstrValid are unchanged; release Stall with PCSrc = 1 -> PC = 32'h40.
4. Retire with PCSrc = 1 and PCTarget = 32'h0000_0042 -> PC = 32'h100, BadAddr = 32'h42, Misaligned high for one cycle, next fetch at 32'h100.
5. PC = 32'hFFFF_FFFC, retire with PCSrc = 0 -> PC = 0, PCPlus4 = 4 before the next retirement, no Misaligned pulse.
6. Assert rst_n = 0 mid-REQ (IMemReq = 1, PC = 32'h20) -> IMemReq = 0 and PC = 0 immediately without a clock edge; after release, the fetch sequence restarts from BOOT.

Source files
------------

// File: rtl/pc_fetch_sequencer.sv
// PC and instruction-fetch sequencer for the multicycle RISC-V core.
// Owns the PC, issues a req/ready fetch to instruction memory, holds the
// fetched word until the core retires it, and traps misaligned redirects.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Stall,
  input  logic        PCSrc,
  input  logic [31:0] PCTarget,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemReady,
  input  logic [31:0] IMemRData,
  output logic [31:0] Instr,
  output logic        InstrValid,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        Misaligned,
  output logic [31:0] BadAddr
);

  localparam logic [31:0] RST_PC  = {RESET_VECTOR[31:2], 2'b00};
  localparam logic [31:0] TRAP_PC = {TRAP_VECTOR[31:2], 2'b00};

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] instr;
  logic        instr_valid;
  logic        misaligned;
  logic [31:0] badaddr;
  logic        fetch_done;
  logic        retire;
  logic        redirect_ok;
  logic        redirect_trap;

  assign pc_plus4 = pc + 32'd4;

  // State register; reset drops IMemReq at once because IMemReq decodes state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BOOT;
    else        state <= state_nxt;
  end

  // Next-state, fetch request and retirement decode
  always_comb begin
    state_nxt     = state;
    IMemReq       = 1'b0;
    fetch_done    = 1'b0;
    retire        = 1'b0;
    redirect_ok   = 1'b0;
    redirect_trap = 1'b0;
    case (state)
      BOOT: state_nxt = REQ;
      REQ: begin
        IMemReq = 1'b1;
        if (IMemReady) begin
          fetch_done = 1'b1;
          state_nxt  = VALID;
        end
      end
      VALID: begin
        if (!Stall) begin
          retire        = 1'b1;
          redirect_ok   = PCSrc && (PCTarget[1:0] == 2'b00);
          redirect_trap = PCSrc && (PCTarget[1:0] != 2'b00);
          state_nxt     = REQ;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  // PC, instruction latch and misaligned-trap capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RST_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      misaligned  <= 1'b0;
      badaddr     <= '0;
    end else begin
      misaligned <= 1'b0;
      if (fetch_done) begin
        instr       <= IMemRData;
        instr_valid <= 1'b1;
      end
      if (retire) begin
        instr_valid <= 1'b0;
        if (redirect_trap) begin
          pc         <= TRAP_PC;
          badaddr    <= PCTarget;
          misaligned <= 1'b1;
        end else if (redirect_ok) begin
          pc <= PCTarget;
        end else begin
          pc <= pc_plus4;
        end
      end
    end
  end

  assign IMemAddr   = pc;
  assign PC         = pc;
  assign PCPlus4    = pc_plus4;
  assign Instr      = instr;
  assign InstrValid = instr_valid;
  assign Misaligned = misaligned;
  assign BadAddr    = badaddr;

endmodule
